// File: rtl/baby_ram_responder_if.sv
// Core RAM port plus the byte-wide host load/dump handshakes of baby_ram_responder.
// checksum_o is present only when BABY_RAM_CHECKSUM_EN is defined.
interface baby_ram_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ram_addr_i;
  logic              ram_rw_en_i;
  logic [DATA_W-1:0] ram_data_i;
  logic [DATA_W-1:0] ram_data_o;
  logic              cpu_hold_o;
  logic              host_load_i;
  logic              host_dump_i;
  logic [7:0]        host_data_i;
  logic              host_valid_i;
  logic              host_ready_o;
  logic [7:0]        host_data_o;
  logic              host_out_valid_o;
  logic              host_out_ready_i;
`ifdef BABY_RAM_CHECKSUM_EN
  logic [7:0]        checksum_o;

  modport master (
    output ram_addr_i, ram_rw_en_i, ram_data_i, host_load_i, host_dump_i,
           host_data_i, host_valid_i, host_out_ready_i,
    input  ram_data_o, cpu_hold_o, host_ready_o, host_data_o, host_out_valid_o,
           checksum_o
  );
  modport slave (
    input  ram_addr_i, ram_rw_en_i, ram_data_i, host_load_i, host_dump_i,
           host_data_i, host_valid_i, host_out_ready_i,
    output ram_data_o, cpu_hold_o, host_ready_o, host_data_o, host_out_valid_o,
           checksum_o
  );
`else
  modport master (
    output ram_addr_i, ram_rw_en_i, ram_data_i, host_load_i, host_dump_i,
           host_data_i, host_valid_i, host_out_ready_i,
    input  ram_data_o, cpu_hold_o, host_ready_o, host_data_o, host_out_valid_o
  );
  modport slave (
    input  ram_addr_i, ram_rw_en_i, ram_data_i, host_load_i, host_dump_i,
           host_data_i, host_valid_i, host_out_ready_i,
    output ram_data_o, cpu_hold_o, host_ready_o, host_data_o, host_out_valid_o
  );
`endif
endinterface

// File: rtl/baby_ram_responder.sv
// Baby core RAM store with a byte-wide host port for program load and memory dump.
// Define BABY_RAM_CHECKSUM_EN to add an 8-bit running sum of host bytes (checksum_o).
//
// state | meaning
// IDLE  | core owns the store; core writes allowed
// LOAD  | host streams bytes in, little-endian, one word per BYTES bytes
// DUMP  | host drains the whole store out, word 0 lane 0 first
module baby_ram_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset_i,
  baby_ram_responder_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] load_word;
  logic [7:0]        dump_byte;

  // Word as it would look with the incoming byte merged into its lane.
  always_comb begin
    load_word = shreg;
    load_word[{byte_cnt, 3'b000} +: 8] = bus.host_data_i;
  end

  assign dump_byte            = mem[ptr][{byte_cnt, 3'b000} +: 8];
  assign bus.ram_data_o       = mem[bus.ram_addr_i];
  assign bus.cpu_hold_o       = (state != IDLE);
  assign bus.host_ready_o     = (state == LOAD);
  assign bus.host_out_valid_o = (state == DUMP);
  assign bus.host_data_o      = (state == DUMP) ? dump_byte : 8'h00;

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      ptr      <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ram_rw_en_i) mem[bus.ram_addr_i] <= bus.ram_data_i;
          if (bus.host_load_i) begin
            state    <= LOAD;
            ptr      <= '0;
            byte_cnt <= '0;
          end else if (bus.host_dump_i) begin
            state    <= DUMP;
            ptr      <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD: begin
          // A byte presented on the edge where load falls is still taken.
          if (bus.host_valid_i) begin
            if (byte_cnt == LAST_BYTE) begin
              mem[ptr] <= load_word;
              ptr      <= ptr + 1'b1;
              byte_cnt <= '0;
            end else begin
              shreg    <= load_word;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          if (!bus.host_load_i) state <= IDLE;
        end
        DUMP: begin
          // Abort wins over a same-edge handshake; that byte is not consumed.
          if (bus.host_load_i) begin
            state <= IDLE;
          end else if (bus.host_out_ready_i) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              ptr      <= ptr + 1'b1;
              if (ptr == LAST_WORD) state <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BABY_RAM_CHECKSUM_EN
  logic [7:0] csum;
  logic       load_fire;
  logic       dump_fire;

  assign load_fire      = (state == LOAD) && bus.host_valid_i;
  assign dump_fire      = (state == DUMP) && bus.host_out_ready_i && !bus.host_load_i;
  assign bus.checksum_o = csum;

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      csum <= 8'h00;
    end else if ((state == IDLE) && (bus.host_load_i || bus.host_dump_i)) begin
      csum <= 8'h00;
    end else if (load_fire) begin
      csum <= csum + bus.host_data_i;
    end else if (dump_fire) begin
      csum <= csum + dump_byte;
    end
  end
`endif
endmodule

// File: tb/tb_baby_ram_responder.sv
// Randomized bench for baby_ram_responder against a byte-stream model of the store.
// Build with BABY_RAM_CHECKSUM_EN defined to also cover checksum_o.
module tb_baby_ram_responder;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int BYTES  = 4;
  localparam int NBYTES = DEPTH * BYTES;

  typedef logic [7:0] byte_q_t[$];
  typedef enum {M_IDLE, M_LOAD, M_DUMP} mode_t;

  logic clock = 1'b0;
  logic reset_i;
  always #5 clock = ~clock;

  baby_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  baby_ram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_i(reset_i), .bus(bus)
  );

  // Reference model: the store as an array, the host side as byte streams.
  mode_t       mode;
  logic [31:0] mmem [DEPTH];
  byte_q_t     pend;
  byte_q_t     dumped;
  int          wptr;
  int          didx;
  logic [7:0]  msum;
  int          passed = 0;
  int          total  = 0;
  bit          addr_free;
  bit          run_checks = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [7:0] stream_byte(input int idx);
    logic [31:0] w;
    w = mmem[idx / BYTES];
    return w[8*(idx % BYTES) +: 8];
  endfunction

  function automatic void model_reset();
    mode = M_IDLE;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    pend.delete();
    wptr = 0;
    didx = 0;
    msum = 8'h00;
  endfunction

  function automatic void model_edge();
    case (mode)
      M_IDLE: begin
        if (bus.ram_rw_en_i) mmem[bus.ram_addr_i] = bus.ram_data_i;
        if (bus.host_load_i) begin
          mode = M_LOAD; pend.delete(); wptr = 0; msum = 8'h00;
        end else if (bus.host_dump_i) begin
          mode = M_DUMP; didx = 0; msum = 8'h00;
        end
      end
      M_LOAD: begin
        if (bus.host_valid_i) begin
          pend.push_back(bus.host_data_i);
          msum = msum + bus.host_data_i;
          if (pend.size() == BYTES) begin
            mmem[wptr] = {pend[3], pend[2], pend[1], pend[0]};
            wptr = (wptr + 1) % DEPTH;
            pend.delete();
          end
        end
        if (!bus.host_load_i) mode = M_IDLE;
      end
      M_DUMP: begin
        if (bus.host_load_i) mode = M_IDLE;
        else if (bus.host_out_ready_i) begin
          dumped.push_back(stream_byte(didx));
          msum = msum + stream_byte(didx);
          didx++;
          if (didx == NBYTES) mode = M_IDLE;
        end
      end
      default: mode = M_IDLE;
    endcase
  endfunction

  always @(negedge clock) begin
    if (run_checks && !reset_i) begin
      chk("ram_data", bus.ram_data_o, mmem[bus.ram_addr_i]);
      chk("cpu_hold", 32'(bus.cpu_hold_o), 32'(mode != M_IDLE));
      chk("host_ready", 32'(bus.host_ready_o), 32'(mode == M_LOAD));
      chk("out_valid", 32'(bus.host_out_valid_o), 32'(mode == M_DUMP));
      if (mode == M_DUMP) chk("host_data", 32'(bus.host_data_o), 32'(stream_byte(didx)));
`ifdef BABY_RAM_CHECKSUM_EN
      chk("checksum", 32'(bus.checksum_o), 32'(msum));
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    if (!reset_i) model_edge();
    #1;
    if (addr_free) bus.ram_addr_i = 5'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic peek(input string name, input int addr, input logic [31:0] exp);
    addr_free = 1'b0;
    bus.ram_addr_i = 5'(addr);
    @(negedge clock);
    chk(name, bus.ram_data_o, exp);
    addr_free = 1'b1;
  endtask

  task automatic do_load(input byte_q_t bytes, input int max_gap, input bit drop_with_last);
    bus.host_load_i = 1'b1;
    tick();
    foreach (bytes[i]) begin
      repeat ($urandom_range(0, max_gap)) tick();
      bus.host_data_i  = bytes[i];
      bus.host_valid_i = 1'b1;
      if (drop_with_last && (i == bytes.size() - 1)) bus.host_load_i = 1'b0;
      tick();
      bus.host_valid_i = 1'b0;
      bus.host_data_i  = 8'($urandom);
    end
    if (bus.host_load_i) begin
      bus.host_load_i = 1'b0;
      tick();
    end
  endtask

  // abort_after < 0 runs a full dump; otherwise load is raised after that many cycles.
  task automatic do_dump(input int abort_after, input int first_exp);
    int n = 0;
    dumped.delete();
    bus.host_dump_i = 1'b1;
    tick();
    bus.host_dump_i = 1'b0;
    if (first_exp >= 0) chk("dump_first_byte", 32'(bus.host_data_o), 32'(first_exp));
    while (mode == M_DUMP && n < 2000) begin
      if (abort_after >= 0 && n == abort_after) begin
        bus.host_out_ready_i = 1'b0;
        bus.host_load_i = 1'b1;
        tick();
        chk("abort_to_idle_hold", 32'(bus.cpu_hold_o), 32'h0);
        tick();
        chk("abort_then_load_ready", 32'(bus.host_ready_o), 32'h1);
        bus.host_load_i = 1'b0;
        tick();
      end else begin
        bus.host_out_ready_i = 1'($urandom_range(0, 1));
        tick();
      end
      n++;
    end
    bus.host_out_ready_i = 1'b0;
    chk("dump_ended", 32'(bus.host_out_valid_o), 32'h0);
  endtask

  initial begin
    byte_q_t lq;
    logic [31:0] w;
    logic [7:0] s;
    reset_i = 1'b1;
    bus.ram_addr_i = '0; bus.ram_rw_en_i = 1'b0; bus.ram_data_i = '0;
    bus.host_load_i = 1'b0; bus.host_dump_i = 1'b0; bus.host_data_i = 8'h00;
    bus.host_valid_i = 1'b0; bus.host_out_ready_i = 1'b0;
    addr_free = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #3 reset_i = 1'b0;
    chk("rst_hold", 32'(bus.cpu_hold_o), 32'h0);
    chk("rst_ready", 32'(bus.host_ready_o), 32'h0);
    chk("rst_out_valid", 32'(bus.host_out_valid_o), 32'h0);
    chk("rst_host_data", 32'(bus.host_data_o), 32'h0);
    run_checks = 1'b1;
    peek("rst_mem_19", 19, 32'h0);

    lq = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(lq, 3, 1'b0);
    peek("load_mem0", 0, 32'h12345678);
    peek("load_mem1", 1, 32'hDEADBEEF);

    lq = {8'h11, 8'h22, 8'h33};
    do_load(lq, 2, 1'b0);
    peek("partial_mem0", 0, 32'h12345678);
    peek("partial_mem2", 2, 32'h0);

    lq = {};
    for (int k = 0; k <= DEPTH; k++) begin
      w = (k == DEPTH) ? 32'hAAAA5555 : 32'(k);
      for (int b = 0; b < BYTES; b++) lq.push_back(w[8*b +: 8]);
    end
    do_load(lq, 1, 1'b1);
    peek("wrap_mem0", 0, 32'hAAAA5555);
    peek("wrap_mem31", 31, 32'd31);
    peek("wrap_mem5", 5, 32'd5);

    addr_free = 1'b0;
    bus.ram_addr_i = 5'd7; bus.ram_data_i = 32'hCAFEF00D; bus.ram_rw_en_i = 1'b1;
    tick();
    bus.ram_rw_en_i = 1'b0;
    @(negedge clock);
    chk("core_write_read", bus.ram_data_o, 32'hCAFEF00D);
    bus.host_load_i = 1'b1;
    tick();
    bus.ram_data_i = 32'h11111111; bus.ram_rw_en_i = 1'b1;
    repeat (2) tick();
    bus.ram_rw_en_i = 1'b0; bus.host_load_i = 1'b0;
    tick();
    addr_free = 1'b1;
    peek("core_write_in_load", 7, 32'hCAFEF00D);

    do_dump(-1, 8'h55);
    chk("dump_len", 32'(dumped.size()), 32'(NBYTES));
    do_dump(17, -1);

`ifdef BABY_RAM_CHECKSUM_EN
    lq = {8'hFF, 8'h02, 8'h00, 8'h00};
    do_load(lq, 2, 1'b0);
    chk("csum_load", 32'(bus.checksum_o), 32'h01);
    do_dump(-1, 8'hFF);
    s = 8'h00;
    foreach (dumped[i]) s = s + dumped[i];
    chk("csum_dump", 32'(bus.checksum_o), 32'(s));
`endif

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          addr_free = 1'b0;
          bus.ram_addr_i = 5'($urandom_range(0, DEPTH - 1));
          bus.ram_data_i = $urandom;
          bus.ram_rw_en_i = 1'b1;
          tick();
          bus.ram_rw_en_i = 1'b0;
          addr_free = 1'b1;
          tick();
        end
        1: begin
          lq = {};
          repeat ($urandom_range(1, 12)) lq.push_back(8'($urandom));
          do_load(lq, 2, 1'($urandom_range(0, 1)));
        end
        2: do_dump(-1, -1);
        default: do_dump($urandom_range(0, 40), -1);
      endcase
    end

    addr_free = 1'b0;
    bus.ram_addr_i = 5'd3; bus.ram_data_i = 32'h5A5A5A5A; bus.ram_rw_en_i = 1'b1;
    tick();
    bus.ram_rw_en_i = 1'b0;
    bus.host_load_i = 1'b1;
    tick();
    bus.host_data_i = 8'hC3; bus.host_valid_i = 1'b1;
    tick();
    #2 reset_i = 1'b1;
    #1;
    chk("midrst_hold", 32'(bus.cpu_hold_o), 32'h0);
    chk("midrst_ready", 32'(bus.host_ready_o), 32'h0);
    chk("midrst_out_valid", 32'(bus.host_out_valid_o), 32'h0);
    chk("midrst_ram_data", bus.ram_data_o, 32'h0);
    bus.host_load_i = 1'b0; bus.host_valid_i = 1'b0;
    model_reset();
    @(posedge clock);
    #3 reset_i = 1'b0;
    addr_free = 1'b1;
    repeat (3) tick();

    run_checks = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
